// File: rtl/lsu_mem_stage_pkg.sv
// Shared constants for the LSU memory stage.
// Holds the RV32I opcode and funct3 encodings used by the LSU, and the
// encoding of the LSU state machine.
package lsu_mem_stage_pkg;

  localparam logic [6:0] opcode_I_ld = 7'b0000011;
  localparam logic [6:0] opcode_S    = 7'b0100011;
  localparam logic [6:0] opcode_B    = 7'b1100011;

  localparam logic [2:0] funct3_lb  = 3'd0;
  localparam logic [2:0] funct3_lh  = 3'd1;
  localparam logic [2:0] funct3_lw  = 3'd2;
  localparam logic [2:0] funct3_lbu = 3'd4;
  localparam logic [2:0] funct3_lhu = 3'd5;
  localparam logic [2:0] funct3_sb  = 3'd0;
  localparam logic [2:0] funct3_sh  = 3'd1;
  localparam logic [2:0] funct3_sw  = 3'd2;

  typedef enum logic [1:0] {
    lsu_IDLE = 2'd0,
    lsu_REQ  = 2'd1,
    lsu_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Combinational byte-lane steering for the LSU.
// Ports:
//   funct3_i   access size/sign
//   is_store_i 1 = store, 0 = load (selects which funct3 values are legal)
//   addr_lo_i  byte offset within the word
//   rs2_i      store data
//   rdata_i    word returned by memory
//   wdata_o    lane-replicated store data
//   wstrb_o    byte strobes (0 for loads)
//   load_o     extracted and extended load value
//   misalign_o access violates natural alignment (only for legal funct3)
//   illegal_o  funct3 undefined for this access type
module lsu_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        is_store_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] load_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = shifted[15:0];

  assign illegal_o = is_store_i ? (funct3_i >= 3'd3)
                                : (funct3_i == 3'd3 || funct3_i >= 3'd6);

  // funct3[1:0] encodes size for both loads and stores: 00 byte, 01 half, 10 word
  always_comb begin
    misalign_o = 1'b0;
    if (!illegal_o) begin
      case (funct3_i[1:0])
        2'b01:   misalign_o = addr_lo_i[0];
        2'b10:   misalign_o = |addr_lo_i;
        default: misalign_o = 1'b0;
      endcase
    end
  end

  always_comb begin
    wdata_o = rs2_i;
    wstrb_o = 4'b0000;
    case (funct3_i)
      funct3_sb: begin
        wdata_o = {4{rs2_i[7:0]}};
        wstrb_o = 4'b0001 << addr_lo_i;
      end
      funct3_sh: begin
        wdata_o = {2{rs2_i[15:0]}};
        wstrb_o = 4'b0011 << addr_lo_i;
      end
      funct3_sw: begin
        wdata_o = rs2_i;
        wstrb_o = 4'b1111;
      end
      default: ;
    endcase
    if (!is_store_i) wstrb_o = 4'b0000;
  end

  always_comb begin
    load_o = rdata_i;
    case (funct3_i)
      funct3_lb:  load_o = {{24{byte_v[7]}}, byte_v};
      funct3_lh:  load_o = {{16{half_v[15]}}, half_v};
      funct3_lw:  load_o = rdata_i;
      funct3_lbu: load_o = {24'd0, byte_v};
      funct3_lhu: load_o = {16'd0, half_v};
      default:    load_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage of the RV32I pipeline.
// Accepts one instruction from EX/MEM while idle, runs a request/grant/
// response bus transaction for loads and stores, and retires to MEM/WB.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           upstream handshake (in_ready = idle)
//   opcode_i, funct3_i, rd_i      decoded instruction fields
//   alu_out_i, rs2_data_i         address/result and store data
//   dmem_req/we/addr/wdata/wstrb  bus request, held until dmem_gnt
//   dmem_gnt, dmem_rvalid, dmem_rdata  bus grant and read response
//   wb_valid/we/rd/data           write-back (wb_valid is a pulse)
//   misalign                      pulse when a misaligned access is dropped
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        rd_i,
  input  logic [31:0]       alu_out_i,
  input  logic [31:0]       rs2_data_i,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              misalign
);

  lsu_state_e state_q, state_d;

  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              wbv_q, wbv_d, wbwe_q, wbwe_d, mis_q, mis_d;
  logic [4:0]        wbrd_q, wbrd_d;
  logic [31:0]       wbdata_q, wbdata_d;
  // access context latched at accept, consumed in REQ/RESP
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lo_q, lo_d;
  logic [4:0]        rd_q, rd_d;
  logic              ld_q, ld_d;

  logic              idle, is_ld_in, is_st_in;
  logic [2:0]        al_f3;
  logic [1:0]        al_lo;
  logic              al_st;
  logic [31:0]       al_wdata, al_load;
  logic [3:0]        al_wstrb;
  logic              al_mis, al_ill;
  logic [ADDR_W-1:0] addr_in;

  assign idle     = (state_q == lsu_IDLE);
  assign in_ready = idle;
  assign is_ld_in = (opcode_i == opcode_I_ld);
  assign is_st_in = (opcode_i == opcode_S);
  assign addr_in  = alu_out_i[ADDR_W-1:0];

  // One aligner serves both phases: live inputs while idle (store steering,
  // alignment check), latched context afterwards (load extraction).
  assign al_f3 = idle ? funct3_i         : f3_q;
  assign al_lo = idle ? alu_out_i[1:0]   : lo_q;
  assign al_st = idle ? is_st_in         : !ld_q;

  lsu_align u_align (
    .funct3_i   (al_f3),
    .is_store_i (al_st),
    .addr_lo_i  (al_lo),
    .rs2_i      (rs2_data_i),
    .rdata_i    (dmem_rdata),
    .wdata_o    (al_wdata),
    .wstrb_o    (al_wstrb),
    .load_o     (al_load),
    .misalign_o (al_mis),
    .illegal_o  (al_ill)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    wbv_d    = 1'b0;
    wbwe_d   = 1'b0;
    wbrd_d   = wbrd_q;
    wbdata_d = wbdata_q;
    mis_d    = 1'b0;
    f3_d     = f3_q;
    lo_d     = lo_q;
    rd_d     = rd_q;
    ld_d     = ld_q;
    case (state_q)
      lsu_IDLE: begin
        if (in_valid) begin
          wbrd_d   = rd_i;
          wbdata_d = alu_out_i;
          if (is_ld_in || is_st_in) begin
            if (al_ill || al_mis) begin
              // dropped: retire without a register write
              wbv_d = 1'b1;
              mis_d = al_mis;
            end else begin
              state_d = lsu_REQ;
              req_d   = 1'b1;
              we_d    = is_st_in;
              addr_d  = {addr_in[ADDR_W-1:2], 2'b00};
              wdata_d = al_wdata;
              wstrb_d = al_wstrb;
              f3_d    = funct3_i;
              lo_d    = alu_out_i[1:0];
              rd_d    = rd_i;
              ld_d    = is_ld_in;
            end
          end else begin
            wbv_d  = 1'b1;
            wbwe_d = (rd_i != 5'd0) && (opcode_i != opcode_B);
          end
        end
      end
      lsu_REQ: begin
        if (dmem_gnt) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
          if (ld_q) begin
            state_d = lsu_RESP;
          end else begin
            state_d = lsu_IDLE;
            wbv_d   = 1'b1;
            wbrd_d  = rd_q;
          end
        end
      end
      lsu_RESP: begin
        if (dmem_rvalid) begin
          state_d  = lsu_IDLE;
          wbv_d    = 1'b1;
          wbwe_d   = (rd_q != 5'd0);
          wbrd_d   = rd_q;
          wbdata_d = al_load;
        end
      end
      default: state_d = lsu_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= lsu_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wbv_q    <= 1'b0;
      wbwe_q   <= 1'b0;
      wbrd_q   <= '0;
      wbdata_q <= '0;
      mis_q    <= 1'b0;
      f3_q     <= '0;
      lo_q     <= '0;
      rd_q     <= '0;
      ld_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wbv_q    <= wbv_d;
      wbwe_q   <= wbwe_d;
      wbrd_q   <= wbrd_d;
      wbdata_q <= wbdata_d;
      mis_q    <= mis_d;
      f3_q     <= f3_d;
      lo_q     <= lo_d;
      rd_q     <= rd_d;
      ld_q     <= ld_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;
  assign wb_valid   = wbv_q;
  assign wb_we      = wbwe_q;
  assign wb_rd      = wbrd_q;
  assign wb_data    = wbdata_q;
  assign misalign   = mis_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic [31:0] alu_out_i, rs2_data_i;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode_i(opcode_i), .funct3_i(funct3_i), .rd_i(rd_i),
    .alu_out_i(alu_out_i), .rs2_data_i(rs2_data_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          dly;      // REQ cycles before gnt
    bit          req;      // bus access expected
    logic [3:0]  wstrb;
    logic [31:0] wdata;    // checked for stores only
    bit          wbwe;
    bit          chk_data;
    logic [31:0] data;
    bit          mis;
  } vec_t;

  vec_t v[16];

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rs2);
    in_valid = 1'b1; opcode_i = op; funct3_i = f3; rd_i = rd;
    alu_out_i = alu; rs2_data_i = rs2;
  endtask

  task automatic run_vec(input vec_t t);
    logic [31:0] a_exp;
    a_exp = {t.alu[31:2], 2'b00};
    @(negedge clk);
    chk({t.name, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    issue(t.op, t.f3, t.rd, t.alu, t.rs2);
    @(negedge clk);
    in_valid = 1'b0;
    if (t.req) begin
      for (int k = 0; k <= t.dly; k++) begin
        chk({t.name, ".req"},   {31'd0, dmem_req}, 32'd1);
        chk({t.name, ".ready0"},{31'd0, in_ready}, 32'd0);
        chk({t.name, ".addr"},  dmem_addr, a_exp);
        chk({t.name, ".we"},    {31'd0, dmem_we}, {31'd0, t.op == OP_ST});
        chk({t.name, ".wstrb"}, {28'd0, dmem_wstrb}, {28'd0, t.wstrb});
        if (t.op == OP_ST) chk({t.name, ".wdata"}, dmem_wdata, t.wdata);
        chk({t.name, ".wbv_req"}, {31'd0, wb_valid}, 32'd0);
        if (k == t.dly) dmem_gnt = 1'b1;
        @(negedge clk);
      end
      dmem_gnt = 1'b0;
      chk({t.name, ".req_drop"}, {31'd0, dmem_req}, 32'd0);
      if (t.op == OP_LD) begin
        chk({t.name, ".wbv_resp"}, {31'd0, wb_valid}, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = t.rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
      end
    end else begin
      chk({t.name, ".no_req"}, {31'd0, dmem_req}, 32'd0);
    end
    chk({t.name, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({t.name, ".wb_we"},    {31'd0, wb_we}, {31'd0, t.wbwe});
    chk({t.name, ".wb_rd"},    {27'd0, wb_rd}, {27'd0, t.rd});
    chk({t.name, ".misalign"}, {31'd0, misalign}, {31'd0, t.mis});
    if (t.chk_data) chk({t.name, ".wb_data"}, wb_data, t.data);
    @(negedge clk);
    chk({t.name, ".wbv_pulse"}, {31'd0, wb_valid}, 32'd0);
    chk({t.name, ".mis_pulse"}, {31'd0, misalign}, 32'd0);
  endtask

  initial begin
    //        name      op      f3  rd  alu            rs2            rdata          dly req wstrb    wdata          wbwe chk data           mis
    v[0]  = '{"addi",   OP_IMM, 3'd0, 5,  32'h0000_1234, 32'h0,        32'h0,         0, 0, 4'b0000, 32'h0,         1, 1, 32'h0000_1234, 0};
    v[1]  = '{"beq",    OP_BR,  3'd0, 3,  32'h0000_0040, 32'h0,        32'h0,         0, 0, 4'b0000, 32'h0,         0, 0, 32'h0,         0};
    v[2]  = '{"sb",     OP_ST,  3'd0, 0,  32'h0000_0103, 32'hAABBCCDD, 32'h0,         3, 1, 4'b1000, 32'hDDDDDDDD,  0, 0, 32'h0,         0};
    v[3]  = '{"sh",     OP_ST,  3'd1, 0,  32'h0000_0002, 32'h11223344, 32'h0,         0, 1, 4'b1100, 32'h33443344,  0, 0, 32'h0,         0};
    v[4]  = '{"sw",     OP_ST,  3'd2, 0,  32'h0000_0010, 32'hCAFEF00D, 32'h0,         1, 1, 4'b1111, 32'hCAFEF00D,  0, 0, 32'h0,         0};
    v[5]  = '{"lb",     OP_LD,  3'd0, 7,  32'h0000_0202, 32'h0,        32'h0080_0000, 0, 1, 4'b0000, 32'h0,         1, 1, 32'hFFFF_FF80, 0};
    v[6]  = '{"lbu",    OP_LD,  3'd4, 7,  32'h0000_0202, 32'h0,        32'h0080_0000, 0, 1, 4'b0000, 32'h0,         1, 1, 32'h0000_0080, 0};
    v[7]  = '{"lh",     OP_LD,  3'd1, 8,  32'h0000_0202, 32'h0,        32'h8001_0000, 0, 1, 4'b0000, 32'h0,         1, 1, 32'hFFFF_8001, 0};
    v[8]  = '{"lhu",    OP_LD,  3'd5, 8,  32'h0000_0202, 32'h0,        32'h8001_0000, 2, 1, 4'b0000, 32'h0,         1, 1, 32'h0000_8001, 0};
    v[9]  = '{"lw",     OP_LD,  3'd2, 9,  32'h0000_0300, 32'h0,        32'h1234_5678, 0, 1, 4'b0000, 32'h0,         1, 1, 32'h1234_5678, 0};
    v[10] = '{"lw_mis", OP_LD,  3'd2, 9,  32'h0000_0301, 32'h0,        32'h0,         0, 0, 4'b0000, 32'h0,         0, 0, 32'h0,         1};
    v[11] = '{"sh_mis", OP_ST,  3'd1, 0,  32'h0000_0001, 32'h1,        32'h0,         0, 0, 4'b0000, 32'h0,         0, 0, 32'h0,         1};
    v[12] = '{"lb_x0",  OP_LD,  3'd0, 0,  32'h0000_0202, 32'h0,        32'h0080_0000, 0, 1, 4'b0000, 32'h0,         0, 1, 32'hFFFF_FF80, 0};
    v[13] = '{"ld_ill", OP_LD,  3'd3, 4,  32'h0000_0400, 32'h0,        32'h0,         0, 0, 4'b0000, 32'h0,         0, 0, 32'h0,         0};
    v[14] = '{"st_ill", OP_ST,  3'd5, 0,  32'h0000_0401, 32'h0,        32'h0,         0, 0, 4'b0000, 32'h0,         0, 0, 32'h0,         0};
    v[15] = '{"lb_b1",  OP_LD,  3'd0, 10, 32'h0000_0201, 32'h0,        32'h0000_7F00, 1, 1, 4'b0000, 32'h0,         1, 1, 32'h0000_007F, 0};

    rst = 1'b1; in_valid = 1'b0; opcode_i = '0; funct3_i = '0; rd_i = '0;
    alu_out_i = '0; rs2_data_i = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.req",      {31'd0, dmem_req}, 32'd0);
    chk("rst.we",       {31'd0, dmem_we}, 32'd0);
    chk("rst.addr",     dmem_addr, 32'd0);
    chk("rst.wstrb",    {28'd0, dmem_wstrb}, 32'd0);
    chk("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst.wb_data",  wb_data, 32'd0);
    chk("rst.misalign", {31'd0, misalign}, 32'd0);

    for (int i = 0; i < 16; i++) run_vec(v[i]);

    // back-to-back non-memory ops: one retire per cycle, never stalls
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      issue(OP_IMM, 3'd0, 5'(i + 1), 32'h100 + i, 32'h0);
      @(negedge clk);
      chk("b2b.in_ready", {31'd0, in_ready}, 32'd1);
      chk("b2b.wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("b2b.wb_rd",    {27'd0, wb_rd}, i + 1);
      chk("b2b.wb_data",  wb_data, 32'h100 + i);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b.end", {31'd0, wb_valid}, 32'd0);

    // spurious rvalid while idle
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("spur.wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("spur.in_ready", {31'd0, in_ready}, 32'd1);

    // reset while a load waits in RESP
    issue(OP_LD, 3'd2, 5'd6, 32'h0000_0500, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstresp.req", {31'd0, dmem_req}, 32'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("rstresp.in_resp", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstresp.idle",   {31'd0, in_ready}, 32'd1);
    chk("rstresp.req0",   {31'd0, dmem_req}, 32'd0);
    chk("rstresp.wbv0",   {31'd0, wb_valid}, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("rstresp.late_rv", {31'd0, wb_valid}, 32'd0);
    issue(OP_IMM, 3'd0, 5'd12, 32'h0000_0777, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstresp.addi_v",  {31'd0, wb_valid}, 32'd1);
    chk("rstresp.addi_we", {31'd0, wb_we}, 32'd1);
    chk("rstresp.addi_d",  wb_data, 32'h0000_0777);
    chk("rstresp.addi_rd", {27'd0, wb_rd}, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Memory-access stage of the 5-stage RV32I pipeline, sitting between the EX/MEM pipeline register and MEM/WB. It consumes the execute stage's outputs: `alu_out` is the effective address or result, `rs2_data` is the forwarded store data, and `opcode`, `funct3` and `rd` come along with them. It drives a request/grant/response data-memory bus, performing byte-lane steering, write-strobe generation, load extraction and sign/zero extension. It stalls upstream while a bus transaction is outstanding.

## Interface
Parameters:
- `ADDR_W`, default 32, data-memory address width; the low 2 bits of `dmem_addr` are always 0.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  EX/MEM register holds an instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle; 0 means upstream holds (stall).
- `opcode_i`  in  7  instruction opcode.
- `funct3_i`  in  3  instruction funct3.
- `rd_i`  in  5  destination register.
- `alu_out_i`  in  32  ALU result or effective address.
- `rs2_data_i`  in  32  store data, already forwarded.
- `dmem_req`  out  1  bus request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  ADDR_W  word-aligned address.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_wstrb`  out  4  byte write strobes.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  32  read word.
- `wb_valid`  out  1  one-cycle pulse: instruction retired to MEM/WB.
- `wb_we`  out  1  register-file write enable, qualified by `wb_valid`.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  32  write-back value.
- `misalign`  out  1  one-cycle pulse: misaligned access was dropped.

## Operation
- FSM states are IDLE, REQ and RESP. `in_ready` = 1 only in IDLE.
- **Non-memory instruction accepted in IDLE:**
  - Next cycle: `wb_valid`=1, `wb_data`=`alu_out_i`, `wb_rd`=`rd_i`.
  - `wb_we` = (`rd_i`≠0) and opcode is not branch.
  - State stays IDLE.
- **Load or store accepted in IDLE:**
  - Alignment rule: lh/lhu/sh require addr[0]=0; lw/sw require addr[1:0]=0.
  - Misaligned: no bus access; next cycle `misalign`=1 and `wb_valid`=1 with `wb_we`=0.
  - Undefined funct3 (loads 3/6/7, stores 3–7): no access, `wb_valid`=1, `wb_we`=0, `misalign`=0.
  - Otherwise: latch the request and go to REQ.
- **REQ state:**
  - `dmem_req`=1; `dmem_addr`, `dmem_we`, `dmem_wdata` and `dmem_wstrb` are held stable until `dmem_gnt`.
  - On gnt for a store: go to IDLE; next cycle `wb_valid`=1 with `wb_we`=0.
  - On gnt for a load: go to RESP and drop `dmem_req`.
- **RESP state:**
  - `dmem_rvalid` is sampled only in RESP; the bus guarantees rvalid arrives no earlier than the cycle after gnt.
  - On rvalid: extract the byte/half at addr[1:0] and extend (lb/lh sign-extend, lbu/lhu zero-extend, lw full word).
  - Next cycle: `wb_valid`=1, `wb_we`=(`rd_i`≠0), `wb_data`=extended value. Go to IDLE.
- **Store steering:**
  - sb: wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - sh: wdata={2{rs2[15:0]}}, wstrb=4'b0011<<addr[1:0].
  - sw: wdata=rs2, wstrb=4'b1111.
  - Loads drive wstrb=0 and we=0.
- A `dmem_rvalid` seen in IDLE or REQ is ignored.

## Timing
- Reset values: state=IDLE, `in_ready`=1, all other outputs 0 (`dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_wstrb`, `wb_*`, `misalign`).
- All outputs are registered except `in_ready`, which decodes directly from state.
- Latency:
  - Non-memory or dropped instruction: 1 cycle from accept to `wb_valid`.
  - Store with gnt in the first REQ cycle: `dmem_req` in cycle 1, `wb_valid` in cycle 2.
  - Load with gnt in cycle 1 and rvalid in cycle 2: `wb_valid` in cycle 3.
- Throughput is 1 instruction/cycle for non-memory instructions; a memory instruction blocks acceptance until the state returns to IDLE.
- `rst` asserted in REQ or RESP: state=IDLE and `dmem_req`=0 in the next cycle, no `wb_valid` for the aborted instruction, and a late rvalid is ignored.
- `wb_valid` and `misalign` are never asserted for more than one cycle per instruction.

## Structure
- Opcode and funct3 constants (`opcode_I_ld`, `opcode_S`, `opcode_B`, `funct3_lb`…`funct3_sw`) come from the shared `define.v`. Add `lsu_IDLE`/`lsu_REQ`/`lsu_RESP` encodings there as well.
- One combinational sub-module, `lsu_align`, takes funct3, addr[1:0], rs2 and rdata. It produces wdata, wstrb, the extended load value, `misalign` and an illegal-funct3 flag.

## Test plan
- Non-memory op: addi result alu_out=0x0000_1234, rd=5 -> next cycle wb_valid=1, wb_we=1, wb_data=0x1234; `in_ready` never drops.
- sb with addr=0x103, rs2=0xAABBCCDD, gnt delayed 3 cycles -> dmem_addr=0x100, wstrb=4'b1000, wdata=0xDDDDDDDD held stable for all 4 REQ cycles; `in_ready`=0 throughout; wb_valid with wb_we=0 one cycle after gnt.
- lb at addr=0x202, rdata=0x0080_0000 -> wb_data=0xFFFFFF80. Same access as lbu -> 0x00000080. lh at addr=0x202, rdata=0x8001_0000 -> 0xFFFF8001.
- lw at addr=0x301 -> no dmem_req, misalign=1 for one cycle, wb_valid=1, wb_we=0. sh at addr=0x001 -> same response.
- Load to rd=0 -> wb_we=0. Spurious rvalid while in IDLE -> no wb_valid.
- rst asserted in the RESP state (load in flight) -> next cycle state=IDLE, dmem_req=0, no wb_valid. A following rvalid is ignored, and a subsequent addi is accepted and retires normally.
